dlatch_wr_arbiter: RTL and testbench

//  Round-robin arbiter and write sequencer for one shared WIDTH-bit level-sensitive
//  D-latch bank. Grants one of NREQ requesters and drives the latch bank's d/en/clear

---
 rtl/dlatch_wr_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_dlatch_wr_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlatch_wr_arbiter.sv
// dlatch_wr_arbiter: round-robin arbiter and write sequencer for a shared
// level-sensitive D-latch bank. A granted write is driven as a timed
// SETUP -> ENABLE -> HOLD sequence, so latch setup/hold hold by construction,
// followed by a one-cycle ack in DONE.
// Optional feature: define DLATCH_ARB_VERIFY_EN to add the lat_q readback port
// and a sticky err flag that reports a readback mismatch in the last HOLD cycle.
// Without the macro there is no lat_q port and err is tied to 0.
module dlatch_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int EN_CYC    = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  ack,
  output logic                  busy,
  output logic [WIDTH-1:0]      lat_d,
  output logic                  lat_en,
  output logic                  lat_clr,
`ifdef DLATCH_ARB_VERIFY_EN
  input  logic [WIDTH-1:0]      lat_q,
`endif
  output logic                  err
);

  localparam int MAX_SE  = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int MAX_CYC = (MAX_SE > HOLD_CYC) ? MAX_SE : HOLD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_MAX    = IDX_W'(NREQ - 1);

  typedef enum logic [2:0] {IDLE, SETUP, ENABLE, HOLD, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [IDX_W-1:0]  win_q, win_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  lat_d_q, lat_d_d;
  logic              lat_en_q, lat_en_d;
  logic              lat_clr_q, lat_clr_d;
`ifdef DLATCH_ARB_VERIFY_EN
  logic              err_q, err_d;
`endif

  logic              found;
  logic [IDX_W-1:0]  sel;
  logic [NREQ-1:0]   sel_oh;
  logic [WIDTH-1:0]  sel_data;

  // Round-robin pick: first asserted request scanning from rr_q upward (mod NREQ).
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    found    = 1'b0;
    sel      = '0;
    sel_oh   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[(int'(rr_q) + i) % NREQ]) begin
        found = 1'b1;
        sel   = IDX_W'((int'(rr_q) + i) % NREQ);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (found && (sel == IDX_W'(i))) begin
        sel_oh[i] = 1'b1;
        sel_data  = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and next-output logic of the write sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    win_d     = win_q;
    gnt_d     = gnt_q;
    ack_d     = 1'b0;
    lat_d_d   = lat_d_q;
    lat_en_d  = 1'b0;
    lat_clr_d = rst;
`ifdef DLATCH_ARB_VERIFY_EN
    err_d     = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SETUP;
          cnt_d   = '0;
          win_d   = sel;
          gnt_d   = sel_oh;
          lat_d_d = sel_data;   // data captured only here; later wdata changes ignored
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d  = ENABLE;
          cnt_d    = '0;
          lat_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ENABLE: begin
        if (cnt_q == EN_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          lat_en_d = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          ack_d   = 1'b1;
`ifdef DLATCH_ARB_VERIFY_EN
          if (lat_q != lat_d_q) err_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        rr_d    = (win_q == IDX_MAX) ? '0 : win_q + IDX_W'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_q     <= '0;
      win_q    <= '0;
      gnt_q    <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      lat_d_q  <= '0;
      lat_en_q <= 1'b0;
`ifdef DLATCH_ARB_VERIFY_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      win_q    <= win_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      lat_d_q  <= lat_d_d;
      lat_en_q <= lat_en_d;
`ifdef DLATCH_ARB_VERIFY_EN
      err_q    <= err_d;
`endif
    end
    lat_clr_q <= lat_clr_d;   // follows rst, so it clears on the first edge with rst low
  end

  assign gnt     = gnt_q;
  assign ack     = ack_q;
  assign busy    = busy_q;
  assign lat_d   = lat_d_q;
  assign lat_en  = lat_en_q;
  assign lat_clr = lat_clr_q;
`ifdef DLATCH_ARB_VERIFY_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_dlatch_wr_arbiter.sv
// Bench for dlatch_wr_arbiter: default-timing instance plus a second instance
// with SETUP_CYC=2, EN_CYC=1, HOLD_CYC=3. Completed writes are scoreboarded:
// the expected grant/data/err is queued when a request is driven and popped on ack.
module tb_dlatch_wr_arbiter;

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  gnt;
  logic        ack, busy, lat_en, lat_clr, err;
  logic [7:0]  lat_d;

  logic [3:0]  req2 = '0;
  logic [31:0] wdata2 = '0;
  logic [3:0]  gnt2;
  logic        ack2, busy2, lat_en2, lat_clr2, err2;
  logic [7:0]  lat_d2;

  logic [31:0] wd_base = {8'h43, 8'h32, 8'h21, 8'h10};
  logic [15:0] status;

  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb[$];

  assign status = {gnt, ack, busy, lat_en, lat_clr, lat_d};

`ifdef DLATCH_ARB_VERIFY_EN
  // Behavioural latch bank; stuck forces its readback to zero.
  logic [7:0] latch_m;
  logic [7:0] lat_q;
  logic       stuck = 1'b0;
  always @* begin
    if (lat_clr === 1'b1)     latch_m = 8'h00;
    else if (lat_en === 1'b1) latch_m = lat_d;
  end
  assign lat_q = stuck ? 8'h00 : latch_m;
`endif

  dlatch_wr_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .gnt(gnt), .ack(ack), .busy(busy), .lat_d(lat_d),
    .lat_en(lat_en), .lat_clr(lat_clr),
`ifdef DLATCH_ARB_VERIFY_EN
    .lat_q(lat_q),
`endif
    .err(err)
  );

  dlatch_wr_arbiter #(.SETUP_CYC(2), .EN_CYC(1), .HOLD_CYC(3)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .wdata(wdata2),
    .gnt(gnt2), .ack(ack2), .busy(busy2), .lat_d(lat_d2),
    .lat_en(lat_en2), .lat_clr(lat_clr2),
`ifdef DLATCH_ARB_VERIFY_EN
    .lat_q(lat_d2),
`endif
    .err(err2)
  );

  always #5 clk = ~clk;

  // Expected {gnt, ack, busy, lat_en, lat_clr, lat_d} in cycle c of a default-timing write.
  function automatic logic [15:0] exp_txn(int c, logic [3:0] g, logic [7:0] d);
    logic act;
    act = (c >= 1 && c <= 5);
    return {act ? g : 4'b0000, c == 5, act, (c == 2 || c == 3), 1'b0, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every ack pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ack === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL sb_unexpected_ack gnt=%b lat_d=%h", gnt, lat_d);
      end else begin
        e = sb.pop_front();
        if ({gnt, lat_d, err} !== {e.gnt, e.data, e.err}) begin
          n_miss++;
          $display("FAIL sb_ack got gnt=%b d=%h err=%b, exp gnt=%b d=%h err=%b",
                   gnt, lat_d, err, e.gnt, e.data, e.err);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({status, err} !== {4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0}) begin
      n_miss++;
      $display("FAIL reset_state got=%h err=%b exp=%h err=0", status, err, 16'h0100);
    end
    n_vec++;
    if ({gnt2, ack2, busy2, lat_en2, lat_clr2, lat_d2} !== {4'b0000, 4'b0001, 8'h00}) begin
      n_miss++;
      $display("FAIL reset_state2 gnt=%b lat_en=%b lat_clr=%b lat_d=%h", gnt2, lat_en2, lat_clr2, lat_d2);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (status !== 16'h0000) begin
      n_miss++;
      $display("FAIL reset_release got=%h exp=0000", status);
    end
  endtask

  task automatic test_single();
    wdata = {wd_base[31:8], 8'hA5};
    req   = 4'b0001;
    sb.push_back('{4'b0001, 8'hA5, 1'b0});
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) req = '0;
      n_vec++;
      if (status !== exp_txn(c, 4'b0001, 8'hA5)) begin
        n_miss++;
        $display("FAIL single c%0d got=%h exp=%h", c, status, exp_txn(c, 4'b0001, 8'hA5));
      end
    end
    wdata = wd_base;
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    logic [7:0] d;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << (k % 4);
      d = wd_base[(k % 4)*8 +: 8];
      sb.push_back('{g, d, 1'b0});
      for (int c = 1; c <= 6; c++) begin
        tick();
        if (c == 1 && k == 4) req = '0;
        n_vec++;
        if (status !== exp_txn(c, g, d)) begin
          n_miss++;
          $display("FAIL rr k%0d c%0d got=%h exp=%h", k, c, status, exp_txn(c, g, d));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    // rr pointer is 1 here; only requester 0 asks, so it wins.
    req = 4'b0001;
    for (int c = 1; c <= 2; c++) begin
      tick();
      if (c == 1) req = '0;
      n_vec++;
      if (status !== exp_txn(c, 4'b0001, 8'h10)) begin
        n_miss++;
        $display("FAIL midrst_pre c%0d got=%h exp=%h", c, status, exp_txn(c, 4'b0001, 8'h10));
      end
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if ({status, err} !== {16'h0100, 1'b0}) begin
      n_miss++;
      $display("FAIL midrst_state got=%h err=%b exp=0100 err=0", status, err);
    end
    // After reset the scan restarts at 0, so 0101 picks requester 0 (not 2).
    rst = 1'b0;
    req = 4'b0101;
    sb.push_back('{4'b0001, 8'h10, 1'b0});
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) req = '0;
      n_vec++;
      if (status !== exp_txn(c, 4'b0001, 8'h10)) begin
        n_miss++;
        $display("FAIL midrst_post c%0d got=%h exp=%h", c, status, exp_txn(c, 4'b0001, 8'h10));
      end
    end
  endtask

  task automatic test_drop_req();
    req = 4'b0010;
    sb.push_back('{4'b0010, 8'h21, 1'b0});
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) req = '0;
      n_vec++;
      if (status !== exp_txn(c, 4'b0010, 8'h21)) begin
        n_miss++;
        $display("FAIL drop c%0d got=%h exp=%h", c, status, exp_txn(c, 4'b0010, 8'h21));
      end
    end
    // Pointer now 2: 1011 goes to requester 3; wdata change after grant is ignored.
    req = 4'b1011;
    sb.push_back('{4'b1000, 8'h43, 1'b0});
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) begin
        req   = '0;
        wdata = {8'hFF, wd_base[23:0]};
      end
      n_vec++;
      if (status !== exp_txn(c, 4'b1000, 8'h43)) begin
        n_miss++;
        $display("FAIL next3 c%0d got=%h exp=%h", c, status, exp_txn(c, 4'b1000, 8'h43));
      end
    end
    wdata = wd_base;
  endtask

  task automatic test_verify();
    wdata = {wd_base[31:8], 8'h3C};
`ifdef DLATCH_ARB_VERIFY_EN
    stuck = 1'b1;
    req   = 4'b0001;
    sb.push_back('{4'b0001, 8'h3C, 1'b1});
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) req = '0;
      n_vec++;
      if ({status, err} !== {exp_txn(c, 4'b0001, 8'h3C), c >= 5}) begin
        n_miss++;
        $display("FAIL verify_bad c%0d got=%h err=%b exp=%h err=%b", c, status, err,
                 exp_txn(c, 4'b0001, 8'h3C), c >= 5);
      end
    end
    stuck = 1'b0;
    req   = 4'b0010;
    sb.push_back('{4'b0010, 8'h21, 1'b1});
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) req = '0;
      n_vec++;
      if ({status, err} !== {exp_txn(c, 4'b0010, 8'h21), 1'b1}) begin
        n_miss++;
        $display("FAIL verify_sticky c%0d got=%h err=%b exp=%h err=1", c, status, err,
                 exp_txn(c, 4'b0010, 8'h21));
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if (err !== 1'b0) begin
      n_miss++;
      $display("FAIL verify_rst_err got=%b exp=0", err);
    end
`else
    req = 4'b0001;
    sb.push_back('{4'b0001, 8'h3C, 1'b0});
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) req = '0;
      n_vec++;
      if ({status, err} !== {exp_txn(c, 4'b0001, 8'h3C), 1'b0}) begin
        n_miss++;
        $display("FAIL noverify c%0d got=%h err=%b exp=%h err=0", c, status, err,
                 exp_txn(c, 4'b0001, 8'h3C));
      end
    end
`endif
    wdata = wd_base;
  endtask

  task automatic test_timing_params();
    logic [14:0] exp2;
    wdata2 = {24'h0, 8'h5A};
    req2   = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) req2 = '0;
      exp2 = {(c <= 7) ? 4'b0001 : 4'b0000, c == 7, c <= 7, c == 3, 8'h5A};
      n_vec++;
      if ({gnt2, ack2, busy2, lat_en2, lat_d2} !== exp2 || err2 !== 1'b0) begin
        n_miss++;
        $display("FAIL timing2 c%0d got=%h err=%b exp=%h err=0", c,
                 {gnt2, ack2, busy2, lat_en2, lat_d2}, err2, exp2);
      end
    end
  endtask

  initial begin
    wdata = wd_base;
    test_reset();
    test_single();
    test_round_robin();
    test_reset_mid();
    test_drop_req();
    test_verify();
    test_timing_params();
    tick();
    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
